// File: rtl/exu_mem_issue.sv
// Execute-stage memory request issuer: holds one decoded memory op, drives AXI-style
// AR/AW/W channels and hands the completed op to the LSU through a ready/valid register.
module exu_mem_issue #(
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 128,
  parameter int STRB_W    = XLEN / 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_addr,
  input  logic [XLEN-1:0]      in_sdata,
  input  logic [1:0]           in_size,
  input  logic                 in_re,
  input  logic                 in_we,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 arvalid,
  input  logic                 arready,
  output logic [XLEN-1:0]      araddr,
  output logic [2:0]           arsize,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [XLEN-1:0]      awaddr,
  output logic                 wvalid,
  input  logic                 wready,
  output logic [XLEN-1:0]      wdata,
  output logic [STRB_W-1:0]    wstrb,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [2:0]           out_addr_lo,
  output logic                 out_is_load,
  output logic                 out_fault
);

  localparam int OFF_W = $clog2(STRB_W);

  typedef enum logic [1:0] {EMPTY, ISSUE, DONE} state_t;

  state_t                 state, state_next;
  logic [XLEN-1:0]        addr_q, sdata_q;
  logic [1:0]             size_q;
  logic                   re_q, we_q, fault_q;
  logic [PAYLOAD_W-1:0]   payload_q;
  logic                   ar_done, aw_done, w_done;

  logic entry_valid, need_ar, need_w;
  logic ar_ok, aw_ok, w_ok, release_op, accept;
  logic misaligned, in_fault, in_mem;
  logic [7:0] lane_base;

  // Fault classification of the incoming op, evaluated on the cycle it is accepted
  always_comb begin
    misaligned = 1'b0;
    case (in_size)
      2'd0: misaligned = 1'b0;
      2'd1: misaligned = in_addr[0];
      2'd2: misaligned = |in_addr[1:0];
      default: misaligned = |in_addr[2:0];
    endcase
  end

  assign in_fault = misaligned || ((in_size == 2'd3) && (XLEN == 32)) || (in_re && in_we);
  assign in_mem   = !in_fault && (in_re || in_we);

  assign entry_valid = (state != EMPTY);
  assign need_ar     = re_q && !fault_q;
  assign need_w      = we_q && !fault_q;

  assign arvalid = entry_valid && need_ar && !ar_done;
  assign awvalid = entry_valid && need_w && !aw_done;
  assign wvalid  = entry_valid && need_w && !w_done;

  // A handshake happening this cycle already counts as done, so completion has no extra latency
  assign ar_ok = !need_ar || ar_done || (arvalid && arready);
  assign aw_ok = !need_w  || aw_done || (awvalid && awready);
  assign w_ok  = !need_w  || w_done  || (wvalid && wready);

  assign out_valid  = entry_valid && ar_ok && aw_ok && w_ok;
  assign release_op = out_valid && out_ready;
  assign in_ready   = !entry_valid || release_op;
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= EMPTY;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        ar_done <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (arvalid && arready) ar_done <= 1'b1;
        if (awvalid && awready) aw_done <= 1'b1;
        if (wvalid && wready)   w_done  <= 1'b1;
      end
    end
  end

  // Op fields only matter while the entry is valid, so they need no reset
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_q    <= in_addr;
      sdata_q   <= in_sdata;
      size_q    <= in_size;
      re_q      <= in_re;
      we_q      <= in_we;
      fault_q   <= in_fault;
      payload_q <= in_payload;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (accept) state_next = in_mem ? ISSUE : DONE;
      end
      ISSUE, DONE: begin
        if (release_op)
          state_next = accept ? (in_mem ? ISSUE : DONE) : EMPTY;
        else if (state == ISSUE && out_valid)
          state_next = DONE;
      end
      default: state_next = EMPTY;
    endcase
  end

  // Byte lanes: enable mask shifted to the address offset, data replicated across the beat
  always_comb begin
    lane_base = 8'h00;
    case (size_q)
      2'd0: lane_base = 8'h01;
      2'd1: lane_base = 8'h03;
      2'd2: lane_base = 8'h0F;
      default: lane_base = 8'hFF;
    endcase
  end

  assign wstrb = STRB_W'(lane_base) << addr_q[OFF_W-1:0];

  always_comb begin
    wdata = sdata_q;
    case (size_q)
      2'd0: wdata = {STRB_W{sdata_q[7:0]}};
      2'd1: wdata = {(STRB_W/2){sdata_q[15:0]}};
      2'd2: wdata = {(XLEN/32){sdata_q[31:0]}};
      default: wdata = sdata_q;
    endcase
  end

  assign araddr      = addr_q;
  assign awaddr      = addr_q;
  assign arsize      = {1'b0, size_q};
  assign out_payload = payload_q;
  assign out_addr_lo = {(XLEN == 64) ? addr_q[2] : 1'b0, addr_q[1:0]};
  assign out_is_load = re_q;
  assign out_fault   = fault_q;

endmodule

// File: tb/tb_exu_mem_issue.sv
// Self-checking bench for exu_mem_issue: directed scenarios plus randomized traffic
// against a transaction-level reference model (XLEN=32), with a 64-bit instance for doubleword lanes.
module tb_exu_mem_issue;

  localparam int PW = 128;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          in_valid, in_re, in_we;
  logic [31:0]   in_addr, in_sdata;
  logic [1:0]    in_size;
  logic [PW-1:0] in_payload;
  logic          arready, awready, wready, out_ready;

  logic          in_ready, arvalid, awvalid, wvalid, out_valid, out_is_load, out_fault;
  logic [31:0]   araddr, awaddr, wdata;
  logic [2:0]    arsize, out_addr_lo;
  logic [3:0]    wstrb;
  logic [PW-1:0] out_payload;

  logic          in_ready64, arvalid64, awvalid64, wvalid64, out_valid64, out_is_load64, out_fault64;
  logic [63:0]   araddr64, awaddr64, wdata64, addr64, sdata64;
  logic [2:0]    arsize64, out_addr_lo64;
  logic [7:0]    wstrb64;
  logic [PW-1:0] out_payload64;

  assign addr64  = {32'h0, in_addr};
  assign sdata64 = {32'h01234567, in_sdata};

  exu_mem_issue #(.XLEN(32), .PAYLOAD_W(PW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_sdata(in_sdata), .in_size(in_size), .in_re(in_re), .in_we(in_we),
    .in_payload(in_payload), .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arsize(arsize), .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_addr_lo(out_addr_lo), .out_is_load(out_is_load), .out_fault(out_fault)
  );

  exu_mem_issue #(.XLEN(64), .PAYLOAD_W(PW)) dut64 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .in_addr(addr64), .in_sdata(sdata64), .in_size(in_size), .in_re(in_re), .in_we(in_we),
    .in_payload(in_payload), .arvalid(arvalid64), .arready(arready), .araddr(araddr64),
    .arsize(arsize64), .awvalid(awvalid64), .awready(awready), .awaddr(awaddr64),
    .wvalid(wvalid64), .wready(wready), .wdata(wdata64), .wstrb(wstrb64),
    .out_valid(out_valid64), .out_ready(out_ready), .out_payload(out_payload64),
    .out_addr_lo(out_addr_lo64), .out_is_load(out_is_load64), .out_fault(out_fault64)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one held op and the set of bus channels it still owes
  bit          m_valid, m_re, m_we, m_fault;
  logic [31:0] m_addr, m_sdata;
  logic [1:0]  m_size;
  logic [PW-1:0] m_pay;
  bit          rem_ar, rem_aw, rem_w;

  task automatic checkOutput(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] expStrb(input logic [31:0] addr, input logic [1:0] size);
    int n = 1 << size;
    int off = int'(addr % 4);
    logic [3:0] m = '0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] expData(input logic [31:0] sdata, input logic [1:0] size);
    int n = 1 << size;
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sdata[8*(i % n) +: 8];
    return r;
  endfunction

  task automatic applyStimulus(input bit rst, input bit iv, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic [1:0] size,
                               input bit re, input bit we, input logic [PW-1:0] pay,
                               input bit arr, input bit awr, input bit wr, input bit outr);
    bit exp_ar, exp_aw, exp_w, hs_ar, hs_aw, hs_w, exp_ov, exp_ir;
    @(posedge clock);
    #1;
    reset = rst; in_valid = iv; in_addr = addr; in_sdata = sdata; in_size = size;
    in_re = re; in_we = we; in_payload = pay;
    arready = arr; awready = awr; wready = wr; out_ready = outr;
    #1;
    exp_ar = m_valid && rem_ar;
    exp_aw = m_valid && rem_aw;
    exp_w  = m_valid && rem_w;
    hs_ar  = exp_ar && arr;
    hs_aw  = exp_aw && awr;
    hs_w   = exp_w && wr;
    exp_ov = m_valid && !(rem_ar && !hs_ar) && !(rem_aw && !hs_aw) && !(rem_w && !hs_w);
    exp_ir = !m_valid || (exp_ov && outr);
    checkOutput("in_ready", in_ready, exp_ir);
    checkOutput("arvalid", arvalid, exp_ar);
    checkOutput("awvalid", awvalid, exp_aw);
    checkOutput("wvalid", wvalid, exp_w);
    checkOutput("out_valid", out_valid, exp_ov);
    if (exp_ar) begin
      checkOutput("araddr", araddr, m_addr);
      checkOutput("arsize", arsize, {1'b0, m_size});
    end
    if (exp_aw) checkOutput("awaddr", awaddr, m_addr);
    if (exp_w) begin
      checkOutput("wdata", wdata, expData(m_sdata, m_size));
      checkOutput("wstrb", wstrb, expStrb(m_addr, m_size));
    end
    if (exp_ov) begin
      checkOutput("out_payload", out_payload, m_pay);
      checkOutput("out_addr_lo", out_addr_lo, {1'b0, m_addr[1:0]});
      checkOutput("out_is_load", out_is_load, m_re);
      checkOutput("out_fault", out_fault, m_fault);
    end
    if (rst) begin
      m_valid = 0; rem_ar = 0; rem_aw = 0; rem_w = 0;
    end else begin
      if (hs_ar) rem_ar = 0;
      if (hs_aw) rem_aw = 0;
      if (hs_w)  rem_w  = 0;
      if (exp_ov && outr) m_valid = 0;
      if (iv && exp_ir) begin
        m_valid = 1; m_addr = addr; m_sdata = sdata; m_size = size;
        m_re = re; m_we = we; m_pay = pay;
        m_fault = (addr % (32'd1 << size) != 0) || (size == 2'd3) || (re && we);
        rem_ar = !m_fault && re;
        rem_aw = !m_fault && we;
        rem_w  = !m_fault && we;
      end
    end
  endtask

  task automatic idle(input bit arr, input bit awr, input bit wr, input bit outr);
    applyStimulus(0, 0, 32'h0, 32'h0, 2'd0, 0, 0, '0, arr, awr, wr, outr);
  endtask

  initial begin
    logic [PW-1:0] pay;
    int kind;
    reset = 1; in_valid = 0; in_addr = '0; in_sdata = '0; in_size = '0; in_re = 0; in_we = 0;
    in_payload = '0; arready = 0; awready = 0; wready = 0; out_ready = 0;
    m_valid = 0; rem_ar = 0; rem_aw = 0; rem_w = 0;
    m_re = 0; m_we = 0; m_fault = 0; m_addr = '0; m_sdata = '0; m_size = '0; m_pay = '0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    checkOutput("reset_in_ready64", in_ready64, 1'b1);

    // Doubleword store: legal on the 64-bit instance, a fault on the 32-bit one
    applyStimulus(0, 1, 32'h80000010, 32'hCAFEF00D, 2'd3, 0, 1, 128'h64, 0, 0, 0, 1);
    idle(1, 1, 1, 1);
    checkOutput("sd64_awvalid", awvalid64, 1'b1);
    checkOutput("sd64_wvalid", wvalid64, 1'b1);
    checkOutput("sd64_arvalid", arvalid64, 1'b0);
    checkOutput("sd64_wstrb", wstrb64, 8'hFF);
    checkOutput("sd64_wdata", wdata64, 64'h01234567CAFEF00D);
    checkOutput("sd64_awaddr", awaddr64, 64'h80000010);
    checkOutput("sd64_araddr", araddr64, 64'h80000010);
    checkOutput("sd64_arsize", arsize64, 3'b011);
    checkOutput("sd64_out_valid", out_valid64, 1'b1);
    checkOutput("sd64_out_fault", out_fault64, 1'b0);
    checkOutput("sd64_is_load", out_is_load64, 1'b0);
    checkOutput("sd64_addr_lo", out_addr_lo64, 3'b000);
    checkOutput("sd64_payload", out_payload64, 128'h64);
    checkOutput("sd32_fault", out_fault, 1'b1);
    idle(0, 0, 0, 1);
    checkOutput("sd64_in_ready", in_ready64, 1'b1);

    // sw, awready first then wready two cycles later
    applyStimulus(0, 1, 32'h80000004, 32'hDEADBEEF, 2'd2, 0, 1, 128'hA1, 0, 0, 0, 0);
    idle(0, 1, 0, 0);
    checkOutput("sw_wstrb", wstrb, 4'hF);
    checkOutput("sw_wdata", wdata, 32'hDEADBEEF);
    idle(0, 0, 0, 0);
    idle(0, 0, 1, 1);

    // sb, wready before awready
    applyStimulus(0, 1, 32'h80000003, 32'h0000005A, 2'd0, 0, 1, 128'hB2, 0, 0, 0, 0);
    idle(0, 0, 1, 0);
    checkOutput("sb_wstrb", wstrb, 4'b1000);
    checkOutput("sb_wdata", wdata, 32'h5A5A5A5A);
    idle(0, 1, 0, 1);

    // misaligned lh
    applyStimulus(0, 1, 32'h80000001, 32'h0, 2'd1, 1, 0, 128'hC3, 0, 0, 0, 0);
    idle(1, 1, 1, 1);
    checkOutput("lh_fault", out_fault, 1'b1);
    checkOutput("lh_arvalid", arvalid, 1'b0);

    // lw with slow arready and held output
    applyStimulus(0, 1, 32'h80000008, 32'h0, 2'd2, 1, 0, 128'hD4, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    checkOutput("lw_arsize", arsize, 3'b010);
    idle(0, 0, 0, 0);
    idle(0, 0, 0, 0);
    idle(1, 0, 0, 0);
    idle(1, 0, 0, 0);
    checkOutput("lw_hold_in_ready", in_ready, 1'b0);
    checkOutput("lw_hold_araddr", araddr, 32'h80000008);
    idle(1, 0, 0, 0);
    idle(0, 0, 0, 1);

    // three back-to-back non-memory ops
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 32'h100 + i, 32'h0, 2'd0, 0, 0, PW'(i + 16), 0, 0, 0, 1);
    idle(0, 0, 0, 1);

    // reset while a store is outstanding
    applyStimulus(0, 1, 32'h80000020, 32'h12345678, 2'd2, 0, 1, 128'hE5, 0, 0, 0, 1);
    idle(0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 1);
    idle(0, 0, 0, 1);
    checkOutput("post_reset_wvalid", wvalid, 1'b0);
    checkOutput("post_reset_awvalid", awvalid, 1'b0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      pay = {$urandom, $urandom, $urandom, $urandom};
      kind = int'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 6),
                    {$urandom} & (($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : 32'hFFFFFFF0),
                    $urandom, 2'($urandom_range(0, 3)),
                    (kind < 3) || (kind == 7), (kind >= 3 && kind < 6) || (kind == 7), pay,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exu_mem_issue.md
Name: exu_mem_issue

Overview:
- Parametrised execute-stage memory request issuer.
- Holds one decoded memory op and drives AXI-style AR, AW and W channels. AW and W handshake independently, in any order.
- Forwards the op and its payload to the LSU stage through a ready/valid pipeline register with backpressure.
- Generalises the single-width, lock-step AW/W issue path to XLEN 32/64, alignment checking and a downstream stall.

Parameters:
- XLEN, 32, data/address width; 32 or 64.
- PAYLOAD_W, 128, opaque side-band bits carried to LSU unchanged.
- STRB_W, XLEN/8, derived; byte lanes per beat.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream op valid
- in_ready  out  1  block can accept op this cycle
- in_addr  in  XLEN  effective byte address
- in_sdata  in  XLEN  store data, LSB-aligned
- in_size  in  2  log2 bytes: 0=B, 1=H, 2=W, 3=D (D legal only if XLEN=64)
- in_re  in  1  load request
- in_we  in  1  store request
- in_payload  in  PAYLOAD_W  side-band (rd, wb ctrl, csr, snpc...)
- arvalid/arready  out/in  1  read address handshake
- araddr  out  XLEN  = latched addr
- arsize  out  3  = {0,size}
- awvalid/awready  out/in  1  write address handshake
- awaddr  out  XLEN  = latched addr
- wvalid/wready  out/in  1  write data handshake
- wdata  out  XLEN  lane-shifted store data
- wstrb  out  STRB_W  byte enables
- out_valid  out  1  op complete, to LSU
- out_ready  in  1  LSU accepts
- out_payload  out  PAYLOAD_W  latched in_payload
- out_addr_lo  out  3  latched addr[2:0] (bit 2 reads 0 when XLEN=32)
- out_is_load  out  1  latched in_re
- out_fault  out  1  misaligned or illegal op; no bus access issued

Behaviour:
- Reset: entry empty. out_valid=0, arvalid=awvalid=wvalid=0, in_ready=1. All done flags cleared.
- Reset mid-handshake drops the entry. No valid is re-asserted afterwards.
- Accept: in_valid && in_ready latches all inputs. Clears the done flags ar_done, aw_done, w_done.
- Bus valids assert the cycle after accept (registered; no input-to-valid combinational path).
- Fault is computed at accept:
  - addr misaligned for size (addr mod 2^size != 0), or
  - size=3 with XLEN=32, or
  - in_re && in_we.
- Faulted or non-memory op (re=we=0): no bus valid ever asserts. out_valid is high the cycle after accept.
- Load: arvalid held until arready. AR fires in the same cycle as the handshake, then ar_done=1.
- Store: awvalid held until awready; wvalid held until wready. Each side drops after its own handshake; either may complete first or both together.
- Valids never deassert before their handshake. araddr/awaddr/wdata/wstrb stay stable while the entry is valid.
- Lane placement, with off = addr[log2(STRB_W)-1:0]:
  - wstrb = ((1<<(1<<size))-1) << off
  - wdata = sdata replicated across lanes, i.e. B repeated STRB_W times, H repeated STRB_W/2 times, etc.
- Completion: out_valid = entry_valid && all required channels done, where a handshake in the current cycle counts as done. Zero extra latency after the last handshake.
- Release: out_valid && out_ready empties the entry.
- in_ready = !entry_valid || (out_valid && out_ready). Back-to-back ops are accepted with no bubble.
- out_ready low: entry, payload and outputs held. No new bus request is issued for a completed channel.
- States: EMPTY -> ISSUE (bus outstanding) -> DONE (waiting out_ready) -> EMPTY, or straight to ISSUE on refill.
  - Faulted and non-memory ops go EMPTY -> DONE.

Test Plan:
- XLEN=32, sw addr 0x80000004 data 0xDEADBEEF; awready cycle 1, wready cycle 3 -> wstrb=4'hF, wdata=0xDEADBEEF, awvalid drops after cycle 1, out_valid in cycle 3.
- XLEN=32, sb addr 0x...03 data 0x5A; wready before awready -> wstrb=4'b1000, wdata=0x5A5A5A5A, out_valid on the awready cycle.
- lh addr 0x...01 -> out_fault=1, no arvalid ever, out_valid 1 cycle after accept.
- lw addr 0x...08, arready after 4 cycles, out_ready low 3 cycles -> araddr stable, arsize=3'b010, payload held, in_ready=0 until release.
- XLEN=64, sd addr 0x...10 -> wstrb=8'hFF, arsize n/a. Same sd with XLEN=32 -> out_fault=1.
- Stream of 3 ALU ops with out_ready=1 -> one accepted per cycle, out_valid continuous. Reset asserted while store outstanding -> all valids 0 the next cycle.
